// File: rtl/baby_control_sequencer.sv
// baby_control_sequencer
// Purpose : cycle-level control sequencer for the Manchester Baby TTL datapath.
//           Each instruction runs as INC / FETCH / EXEC phases. Each phase is
//           SETUP, LATCH and HOLD sub-cycles, so every LE/WE pulse has the bus
//           source driven for one cycle before it and one cycle after it.
// Latency : RUN rising edge to INC SETUP takes 2 cycles, and each phase takes
//           3 cycles. All outputs are registered.
// Flow    : RUN low stops execution at the next instruction boundary. STP halts,
//           and a new RUN rising edge is then needed to restart.
// Config  : SEQ_SINGLE_STEP_EN, when defined, enables STEP. A STEP rising edge
//           seen in HALT runs exactly one instruction.
// Ports   : CLK, RESET (async, active-high), RUN, STEP, OPCODE[2:0], ACC_NEG ->
//           CI/PI/ACC _LE and _OE_n, MEM_OE_n, MEM_WE_n, ADDR_SRC, ALU_OP[2:0],
//           HALTED
module baby_control_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [2:0] OPCODE,
  input  logic       ACC_NEG,
  output logic       CI_LE,
  output logic       PI_LE,
  output logic       ACC_LE,
  output logic       CI_OE_n,
  output logic       PI_OE_n,
  output logic       ACC_OE_n,
  output logic       MEM_OE_n,
  output logic       MEM_WE_n,
  output logic       ADDR_SRC,
  output logic [2:0] ALU_OP,
  output logic       HALTED
);

  typedef enum logic [1:0] {S_HALT, S_INC, S_FETCH, S_EXEC} state_t;

  localparam logic [1:0] SUB_SETUP = 2'd0;
  localparam logic [1:0] SUB_LATCH = 2'd1;
  localparam logic [1:0] SUB_HOLD  = 2'd2;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_INC  = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_NEG  = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_sub, w_sub_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic       r_neg, w_neg_nxt;
  logic       r_run, r_run_prev;
  logic       w_run_edge, w_hold, w_fetch_hold, w_continue;
  logic       w_step_start, w_in_step;

  logic r_ci_le, r_pi_le, r_acc_le, r_ci_oe_n, r_pi_oe_n, r_acc_oe_n;
  logic r_mem_oe_n, r_mem_we_n, r_addr_src, r_halted;
  logic [2:0] r_alu_op;
  logic w_ci_le, w_pi_le, w_acc_le, w_ci_oe_n, w_pi_oe_n, w_acc_oe_n;
  logic w_mem_oe_n, w_mem_we_n, w_addr_src, w_halted, w_latch;
  logic [2:0] w_alu_op;

  assign w_run_edge   = r_run & ~r_run_prev;
  assign w_hold       = (r_sub == SUB_HOLD);
  assign w_fetch_hold = (r_state == S_FETCH) && w_hold;
  // A single-stepped instruction always ends in HALT, whatever RUN says.
  assign w_continue   = r_run & ~w_in_step;

`ifdef SEQ_SINGLE_STEP_EN
  logic r_step, r_step_prev, r_step_mode;

  assign w_step_start = r_step & ~r_step_prev;
  assign w_in_step    = r_step_mode;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_step      <= 1'b0;
      r_step_prev <= 1'b0;
      r_step_mode <= 1'b0;
    end else begin
      r_step      <= STEP;
      r_step_prev <= r_step;
      if (w_state_nxt == S_HALT)
        r_step_mode <= 1'b0;
      else if ((r_state == S_HALT) && w_step_start)
        r_step_mode <= 1'b1;
    end
  end
`else
  logic w_unused_step;
  assign w_unused_step = STEP;
  assign w_step_start  = 1'b0;
  assign w_in_step     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_HALT;
      r_sub      <= SUB_SETUP;
      r_op       <= 3'd0;
      r_neg      <= 1'b0;
      r_run      <= 1'b0;
      r_run_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sub      <= w_sub_nxt;
      r_op       <= w_op_nxt;
      r_neg      <= w_neg_nxt;
      r_run      <= RUN;
      r_run_prev <= r_run;
    end
  end

  // Next state. The opcode is captured on the FETCH HOLD edge. The EXEC choice
  // made on that edge uses the value being captured.
  always_comb begin
    w_state_nxt = r_state;
    w_sub_nxt   = w_hold ? SUB_SETUP : r_sub + 2'd1;
    w_op_nxt    = w_fetch_hold ? OPCODE  : r_op;
    w_neg_nxt   = w_fetch_hold ? ACC_NEG : r_neg;
    unique case (r_state)
      S_HALT: begin
        w_sub_nxt = SUB_SETUP;
        if (w_run_edge || w_step_start) w_state_nxt = S_INC;
      end
      S_INC: if (w_hold) w_state_nxt = S_FETCH;
      S_FETCH: if (w_hold) begin
        if (w_op_nxt == 3'b111)
          w_state_nxt = S_HALT;
        else if ((w_op_nxt == 3'b011) && !w_neg_nxt)
          w_state_nxt = w_continue ? S_INC : S_HALT;
        else
          w_state_nxt = S_EXEC;
      end
      S_EXEC: if (w_hold) w_state_nxt = w_continue ? S_INC : S_HALT;
      default: w_state_nxt = S_HALT;
    endcase
  end

  // Strobes are decoded from the next state and registered, so every output
  // comes from a flop.
  always_comb begin
    w_ci_le = 1'b0;  w_pi_le = 1'b0;  w_acc_le = 1'b0;
    w_ci_oe_n = 1'b1; w_pi_oe_n = 1'b1; w_acc_oe_n = 1'b1;
    w_mem_oe_n = 1'b1; w_mem_we_n = 1'b1;
    w_addr_src = 1'b0; w_alu_op = ALU_PASS; w_halted = 1'b0;
    w_latch = (w_sub_nxt == SUB_LATCH);
    unique case (w_state_nxt)
      S_HALT: w_halted = 1'b1;
      S_INC: begin
        w_ci_oe_n = 1'b0; w_alu_op = ALU_INC; w_ci_le = w_latch;
      end
      S_FETCH: begin
        w_mem_oe_n = 1'b0; w_pi_le = w_latch;
      end
      S_EXEC: begin
        w_addr_src = 1'b1;
        casez (w_op_nxt)
          3'b000: begin                      // JMP
            w_mem_oe_n = 1'b0; w_ci_le = w_latch;
          end
          3'b100: begin                      // JRP
            w_ci_oe_n = 1'b0; w_mem_oe_n = 1'b0; w_alu_op = ALU_ADD; w_ci_le = w_latch;
          end
          3'b010: begin                      // LDN
            w_mem_oe_n = 1'b0; w_alu_op = ALU_NEG; w_acc_le = w_latch;
          end
          3'b110: begin                      // STO
            w_acc_oe_n = 1'b0; w_mem_we_n = ~w_latch;
          end
          3'b?01: begin                      // SUB
            w_acc_oe_n = 1'b0; w_mem_oe_n = 1'b0; w_alu_op = ALU_SUB; w_acc_le = w_latch;
          end
          3'b011: begin                      // CMP taken: an extra INC phase skips
            w_addr_src = 1'b0; w_ci_oe_n = 1'b0; w_alu_op = ALU_INC;
            w_ci_le = w_latch & w_neg_nxt;
          end
          default: ;
        endcase
      end
      default: w_halted = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ci_le <= 1'b0; r_pi_le <= 1'b0; r_acc_le <= 1'b0;
      r_ci_oe_n <= 1'b1; r_pi_oe_n <= 1'b1; r_acc_oe_n <= 1'b1;
      r_mem_oe_n <= 1'b1; r_mem_we_n <= 1'b1;
      r_addr_src <= 1'b0; r_alu_op <= ALU_PASS; r_halted <= 1'b1;
    end else begin
      r_ci_le <= w_ci_le; r_pi_le <= w_pi_le; r_acc_le <= w_acc_le;
      r_ci_oe_n <= w_ci_oe_n; r_pi_oe_n <= w_pi_oe_n; r_acc_oe_n <= w_acc_oe_n;
      r_mem_oe_n <= w_mem_oe_n; r_mem_we_n <= w_mem_we_n;
      r_addr_src <= w_addr_src; r_alu_op <= w_alu_op; r_halted <= w_halted;
    end
  end

  assign CI_LE    = r_ci_le;
  assign PI_LE    = r_pi_le;
  assign ACC_LE   = r_acc_le;
  assign CI_OE_n  = r_ci_oe_n;
  assign PI_OE_n  = r_pi_oe_n;
  assign ACC_OE_n = r_acc_oe_n;
  assign MEM_OE_n = r_mem_oe_n;
  assign MEM_WE_n = r_mem_we_n;
  assign ADDR_SRC = r_addr_src;
  assign ALU_OP   = r_alu_op;
  assign HALTED   = r_halted;

endmodule

// File: tb/tb_baby_control_sequencer.sv
// tb_baby_control_sequencer
// Purpose : directed stimulus pushes per-cycle expected strobe vectors into a
//           scoreboard queue. A monitor pops and compares them on each falling edge.
// Vector  : {CI_LE,PI_LE,ACC_LE, CI_OE_n,PI_OE_n,ACC_OE_n,MEM_OE_n, MEM_WE_n,
//            ADDR_SRC, ALU_OP[2:0], HALTED}
module tb_baby_control_sequencer;
  logic       CLK = 1'b0;
  logic       RESET, RUN, STEP, ACC_NEG;
  logic [2:0] OPCODE;
  logic       CI_LE, PI_LE, ACC_LE, CI_OE_n, PI_OE_n, ACC_OE_n;
  logic       MEM_OE_n, MEM_WE_n, ADDR_SRC, HALTED;
  logic [2:0] ALU_OP;

  baby_control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .OPCODE(OPCODE),
    .ACC_NEG(ACC_NEG), .CI_LE(CI_LE), .PI_LE(PI_LE), .ACC_LE(ACC_LE),
    .CI_OE_n(CI_OE_n), .PI_OE_n(PI_OE_n), .ACC_OE_n(ACC_OE_n),
    .MEM_OE_n(MEM_OE_n), .MEM_WE_n(MEM_WE_n), .ADDR_SRC(ADDR_SRC),
    .ALU_OP(ALU_OP), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  localparam logic [12:0] HALT_V = 13'b000_1111_1_0_000_1;
  localparam logic [12:0] INC_S  = 13'b000_0111_1_0_001_0;
  localparam logic [12:0] INC_L  = 13'b100_0111_1_0_001_0;
  localparam logic [12:0] FET_S  = 13'b000_1110_1_0_000_0;
  localparam logic [12:0] FET_L  = 13'b010_1110_1_0_000_0;
  localparam logic [12:0] JMP_S  = 13'b000_1110_1_1_000_0;
  localparam logic [12:0] JMP_L  = 13'b100_1110_1_1_000_0;
  localparam logic [12:0] JRP_S  = 13'b000_0110_1_1_010_0;
  localparam logic [12:0] JRP_L  = 13'b100_0110_1_1_010_0;
  localparam logic [12:0] LDN_S  = 13'b000_1110_1_1_011_0;
  localparam logic [12:0] LDN_L  = 13'b001_1110_1_1_011_0;
  localparam logic [12:0] STO_S  = 13'b000_1101_1_1_000_0;
  localparam logic [12:0] STO_L  = 13'b000_1101_0_1_000_0;
  localparam logic [12:0] SUB_S  = 13'b000_1100_1_1_100_0;
  localparam logic [12:0] SUB_L  = 13'b001_1100_1_1_100_0;

  typedef struct {
    int          cyc;
    logic [12:0] v;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [12:0] w_obs;

  assign w_obs = {CI_LE, PI_LE, ACC_LE, CI_OE_n, PI_OE_n, ACC_OE_n,
                  MEM_OE_n, MEM_WE_n, ADDR_SRC, ALU_OP, HALTED};

  logic [2:0] prog_op  [7] = '{3'b010, 3'b110, 3'b101, 3'b011, 3'b011, 3'b100, 3'b111};
  logic       prog_neg [7] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge CLK) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp = n_cmp + 1;
      if (e.cyc != cyc) begin
        n_err = n_err + 1;
        $display("FAIL %s: expectation for cycle %0d missed (now cycle %0d)", e.nm, e.cyc, cyc);
      end else if (w_obs !== e.v) begin
        n_err = n_err + 1;
        $display("FAIL %s @cycle %0d: got %b, expected %b", e.nm, cyc, w_obs, e.v);
      end
    end
  end

  task automatic push(input int c, input logic [12:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.v = v; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic push_halt(input int c, input int n, input string nm);
    for (int i = 0; i < n; i++) push(c + i, HALT_V, nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Expected vectors for one instruction whose INC SETUP is at cycle s.
  task automatic push_instr(input int s, input logic [2:0] op, input logic neg,
                            output int len);
    logic [12:0] ex_s, ex_l;
    string       nm;
    push(s,     INC_S, "inc_setup"); push(s + 1, INC_L, "inc_latch");
    push(s + 2, INC_S, "inc_hold");
    push(s + 3, FET_S, "fetch_setup"); push(s + 4, FET_L, "fetch_latch");
    push(s + 5, FET_S, "fetch_hold");
    len = 9; ex_s = HALT_V; ex_l = HALT_V; nm = "exec";
    case (op)
      3'b000: begin ex_s = JMP_S; ex_l = JMP_L; nm = "jmp"; end
      3'b100: begin ex_s = JRP_S; ex_l = JRP_L; nm = "jrp"; end
      3'b010: begin ex_s = LDN_S; ex_l = LDN_L; nm = "ldn"; end
      3'b110: begin ex_s = STO_S; ex_l = STO_L; nm = "sto"; end
      3'b001, 3'b101: begin ex_s = SUB_S; ex_l = SUB_L; nm = "sub"; end
      3'b011: begin
        if (neg) begin ex_s = INC_S; ex_l = INC_L; nm = "cmp_skip"; end
        else len = 6;
      end
      default: len = 6;
    endcase
    if (len == 9) begin
      push(s + 6, ex_s, {nm, "_setup"});
      push(s + 7, ex_l, {nm, "_latch"});
      push(s + 8, ex_s, {nm, "_hold"});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int len;
    RESET = 1'b1; RUN = 1'b0; STEP = 1'b0; OPCODE = 3'b000; ACC_NEG = 1'b0;
    tick(1);
    push_halt(cyc, 2, "reset_state");
    tick(2);
    RESET = 1'b0;
    push_halt(cyc, 3, "idle_after_reset");
    tick(3);

    // Run a program with RUN held high: LDN, STO, SUB, CMP taken, CMP not taken, JRP, STP.
    OPCODE = prog_op[0]; RUN = 1'b1;
    push_halt(cyc, 2, "run_edge_latency");
    s = cyc + 2;
    tick(2);
    for (int i = 0; i < 7; i++) begin
      OPCODE = prog_op[i]; ACC_NEG = prog_neg[i];
      push_instr(s, prog_op[i], prog_neg[i], len);
      tick(len);
      s = s + len;
    end
    // After STP the sequencer stays halted while RUN stays high.
    push_halt(cyc, 6, "stp_run_held");
    tick(6);
    RUN = 1'b0;
    push_halt(cyc, 2, "run_low");
    tick(2);

    // Restart on a fresh edge (JMP). Dropping RUN mid-instruction halts at its end.
    OPCODE = 3'b000; ACC_NEG = 1'b0; RUN = 1'b1;
    push_halt(cyc, 2, "restart_latency");
    s = cyc + 2;
    tick(2);
    push_instr(s, 3'b000, 1'b0, len);
    tick(1);
    RUN = 1'b0;
    tick(len - 1);
    push_halt(cyc, 2, "run_low_stop");
    tick(2);

    // Reset during FETCH LATCH: PI_LE drops in the same cycle.
    RUN = 1'b1;
    push_halt(cyc, 2, "pre_reset_run");
    s = cyc + 2;
    push(s, INC_S, "inc_setup"); push(s + 1, INC_L, "inc_latch");
    push(s + 2, INC_S, "inc_hold"); push(s + 3, FET_S, "fetch_setup");
    tick(6);
    RESET = 1'b1; RUN = 1'b0;
    push_halt(cyc, 2, "reset_mid_fetch");
    tick(2);
    RESET = 1'b0;
    push_halt(cyc, 3, "after_mid_reset");
    tick(3);

    // STEP edge in HALT with RUN low.
    OPCODE = 3'b000; STEP = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    push_halt(cyc, 2, "step_latency");
    s = cyc + 2;
    push_instr(s, 3'b000, 1'b0, len);
    push_halt(s + 9, 2, "step_done_halt");
    tick(13);
`else
    push_halt(cyc, 5, "step_ignored");
    tick(5);
`endif
    STEP = 1'b0;
    tick(2);

    n_cmp = n_cmp + 1;
    if (sb.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
